call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter PC_WIDTH, default 9: width of each saved program-counter value.
REQ-002 Parameter FLAGS_WIDTH, default 4: width of each saved ALU flag word.
REQ-003 Parameter DEPTH, default 8, minimum 2: number of stack entries.
REQ-004 Parameter WRAP_MODE, default 0: 0 = push-when-full dropped; 1 = circular, push-when-full overwrites the oldest entry.
REQ-005 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_push_en  input  1  push request, sampled per cycle.
REQ-009 in_pop_en  input  1  pop request, sampled per cycle.
REQ-010 in_pc  input  PC_WIDTH  return address to push.
REQ-011 in_flags  input  FLAGS_WIDTH  flag word to push with in_pc.
REQ-012 in_clear_err  input  1  clears sticky error flags.
REQ-013 out_pc  output  PC_WIDTH  registered top-of-stack PC.
REQ-014 out_flags  output  FLAGS_WIDTH  registered top-of-stack flags.
REQ-015 out_count  output  clog2(DEPTH+1)  current number of valid entries.
REQ-016 out_empty / out_full  output  1 each  count==0 / count==DEPTH.
REQ-017 out_overflow / out_underflow  output  1 each  sticky error flags.

Function
REQ-018 Push only, not full: entry written at top, count+1; next cycle out_pc/out_flags equal the pushed values.
REQ-019 Pop only, not empty: count-1; next cycle out_pc/out_flags equal the new top entry, or zero if the stack became empty.
REQ-020 Push and pop same cycle, not empty: top entry replaced by {in_pc,in_flags}, count unchanged, no error.
REQ-021 Push and pop same cycle, empty: treated as push only; underflow not set.
REQ-022 Pop only while empty: state unchanged, out_underflow set.
REQ-023 Push only while full, WRAP_MODE=0: push dropped, state unchanged, out_overflow set.
REQ-024 Push only while full, WRAP_MODE=1: oldest entry overwritten, new entry becomes top, count stays DEPTH, out_overflow set.
REQ-025 Storage is a circular buffer indexed by a base pointer and count; pointers wrap modulo DEPTH, including non-power-of-two DEPTH.
REQ-026 out_empty, out_full, out_count derive combinationally from the registered count.
REQ-027 in_clear_err clears both sticky flags next cycle; an error event in the same cycle takes priority and sets its flag.
REQ-028 Zero-latency read-through is not provided; top-of-stack outputs are always one cycle after the causing edge.

Reset
REQ-029 rst_n low immediately forces count=0, base pointer=0, out_pc=0, out_flags=0, out_overflow=0, out_underflow=0, independent of clk.
REQ-030 Storage array contents need not be reset; entries are only observable after being written.
REQ-031 Reset asserted mid-operation discards any in-flight push/pop; first edge after release behaves as on an empty stack.

Structure
REQ-032 Default widths (PC_WIDTH=9, FLAGS_WIDTH=4) and WRAP_MODE encodings live in the shared drfa_pkg package, used also by control_unit.
REQ-033 Storage is one sub-module stack_mem: DEPTH x (PC_WIDTH+FLAGS_WIDTH) register file, one synchronous write port, one asynchronous read port.
REQ-034 Pointer, count and error logic reside in call_stack.

Verification
REQ-035 Reset, push (pc=0x1E1, flags=4'b1001) -> next cycle out_pc=0x1E1, out_flags=4'b1001, out_count=1.
REQ-036 Push 0x010,0x020,0x030 then pop twice -> out_pc 0x030, then 0x020, then 0x010; count 3,2,1.
REQ-037 DEPTH=8, WRAP_MODE=0, 9 pushes 0x001..0x009 -> out_full=1, out_overflow=1, out_pc=0x008; 8 pops return 0x008..0x001.
REQ-038 DEPTH=8, WRAP_MODE=1, 9 pushes 0x001..0x009 -> out_count=8, out_pc=0x009; 8 pops return 0x009..0x002.
REQ-039 Pop on empty -> out_underflow=1, count 0; then in_clear_err -> out_underflow=0; simultaneous push+pop on count 2 with pc=0x0AA -> out_pc=0x0AA, count 2.
REQ-040 rst_n pulsed low between edges with count=3 -> outputs zero immediately; next push of 0x055 yields count=1, out_pc=0x055.

Source files
------------

// File: rtl/drfa_pkg.sv
// Shared widths, wrap-mode encodings and stack operation codes used by call_stack and control_unit.
package drfa_pkg;
  localparam int PC_W_DEF    = 9;
  localparam int FLAGS_W_DEF = 4;
  localparam int WRAP_DROP   = 0;
  localparam int WRAP_CIRC   = 1;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } stk_op_e;
endpackage

// File: rtl/stack_mem.sv
// Call-stack register file: one synchronous write port, one asynchronous read port, no reset.
module stack_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 13,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/call_stack.sv
// Return-address/flags stack kept as a circular buffer (base pointer + count) with registered top-of-stack.
module call_stack
  import drfa_pkg::*;
#(
  parameter int PC_WIDTH    = PC_W_DEF,
  parameter int FLAGS_WIDTH = FLAGS_W_DEF,
  parameter int DEPTH       = 8,
  parameter int WRAP_MODE   = WRAP_DROP
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_push_en,
  input  logic                       in_pop_en,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [FLAGS_WIDTH-1:0]     in_flags,
  input  logic                       in_clear_err,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [FLAGS_WIDTH-1:0]     out_flags,
  output logic [$clog2(DEPTH+1)-1:0] out_count,
  output logic                       out_empty,
  output logic                       out_full,
  output logic                       out_overflow,
  output logic                       out_underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = CW + 1;
  localparam int EW = PC_WIDTH + FLAGS_WIDTH;

  // Inputs are always below 2*DEPTH, so one conditional subtract reduces modulo DEPTH.
  function automatic logic [PW-1:0] mod_d(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = (v >= IW'(DEPTH)) ? v - IW'(DEPTH) : v;
    return r[PW-1:0];
  endfunction

  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          base_q, base_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [FLAGS_WIDTH-1:0] flags_q, flags_d;
  logic                   ovf_q, ovf_d, udf_q, udf_d;

  logic          empty, full, we;
  logic [PW-1:0] waddr, raddr, top_idx, nxt_idx;
  logic [IW-1:0] base_ext, cnt_ext;
  logic [EW-1:0] rdata;
  stk_op_e       op;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign base_ext = IW'(base_q);
  assign cnt_ext  = IW'(count_q);
  assign top_idx  = mod_d(base_ext + cnt_ext - IW'(1));
  assign nxt_idx  = mod_d(base_ext + cnt_ext);
  // Entry just below the top; only meaningful with two or more entries.
  assign raddr    = (count_q >= CW'(2)) ? mod_d(base_ext + cnt_ext - IW'(2)) : '0;

  always_comb begin
    op = OP_NONE;
    if (in_push_en && (!in_pop_en || empty)) op = OP_PUSH;
    else if (in_push_en && in_pop_en)        op = OP_REPL;
    else if (in_pop_en)                      op = OP_POP;
  end

  always_comb begin
    count_d = count_q;
    base_d  = base_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    ovf_d   = in_clear_err ? 1'b0 : ovf_q;
    udf_d   = in_clear_err ? 1'b0 : udf_q;
    we      = 1'b0;
    waddr   = nxt_idx;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          count_d = count_q + CW'(1);
          pc_d    = in_pc;
          flags_d = in_flags;
        end else begin
          ovf_d = 1'b1;
          if (WRAP_MODE == WRAP_CIRC) begin
            // Oldest slot becomes the new top; base advances past it.
            we      = 1'b1;
            waddr   = base_q;
            base_d  = mod_d(base_ext + IW'(1));
            pc_d    = in_pc;
            flags_d = in_flags;
          end
        end
      end
      OP_REPL: begin
        we      = 1'b1;
        waddr   = top_idx;
        pc_d    = in_pc;
        flags_d = in_flags;
      end
      OP_POP: begin
        if (empty) begin
          udf_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            pc_d    = '0;
            flags_d = '0;
          end else begin
            {pc_d, flags_d} = rdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      base_q  <= '0;
      pc_q    <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      base_q  <= base_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  stack_mem #(.DEPTH(DEPTH), .W(EW), .AW(PW)) u_mem (
    .clk     (clk),
    .wr_en   (we),
    .wr_addr (waddr),
    .wr_data ({in_pc, in_flags}),
    .rd_addr (raddr),
    .rd_data (rdata)
  );

  assign out_pc        = pc_q;
  assign out_flags     = flags_q;
  assign out_count     = count_q;
  assign out_empty     = empty;
  assign out_full      = full;
  assign out_overflow  = ovf_q;
  assign out_underflow = udf_q;
endmodule

// File: tb/tb_call_stack.sv
// Scoreboard bench for call_stack: a drop-mode and a circular-mode instance driven in lockstep.
module tb_call_stack;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push = 1'b0, pop = 1'b0, clr = 1'b0;
  logic [8:0] pc = '0;
  logic [3:0] fl = '0;

  logic [8:0] pc0, pc1;
  logic [3:0] fl0, fl1, cnt0, cnt1;
  logic       e0, f0, o0, u0, e1, f1, o1, u1;

  always #5 clk = ~clk;

  call_stack #(.PC_WIDTH(9), .FLAGS_WIDTH(4), .DEPTH(8), .WRAP_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_push_en(push), .in_pop_en(pop), .in_pc(pc),
    .in_flags(fl), .in_clear_err(clr), .out_pc(pc0), .out_flags(fl0), .out_count(cnt0),
    .out_empty(e0), .out_full(f0), .out_overflow(o0), .out_underflow(u0));

  call_stack #(.PC_WIDTH(9), .FLAGS_WIDTH(4), .DEPTH(8), .WRAP_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_push_en(push), .in_pop_en(pop), .in_pc(pc),
    .in_flags(fl), .in_clear_err(clr), .out_pc(pc1), .out_flags(fl1), .out_count(cnt1),
    .out_empty(e1), .out_full(f1), .out_overflow(o1), .out_underflow(u1));

  // {pc, flags, count, full, empty, overflow, underflow}
  logic [20:0] act0, act1;
  assign act0 = {pc0, fl0, cnt0, f0, e0, o0, u0};
  assign act1 = {pc1, fl1, cnt1, f1, e1, o1, u1};

  typedef struct {
    string       nm;
    bit          sel;
    logic [20:0] exp;
  } sb_t;
  sb_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(string nm, logic [20:0] act, logic [20:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got pc=%h fl=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b, want pc=%h fl=%h cnt=%0d full=%b empty=%b ovf=%b udf=%b",
               nm, act[20:12], act[11:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[20:12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endfunction

  function automatic logic [20:0] mk(logic [8:0] p, logic [3:0] f, int c, bit o, bit u);
    return {p, f, 4'(c), (c == 8), (c == 0), o, u};
  endfunction

  // Drive one cycle of stimulus and queue the state expected after the next rising edge.
  task automatic step(string nm, bit sel, bit ps, bit pp, logic [8:0] ipc, logic [3:0] ifl,
                      bit iclr, logic [8:0] epc, logic [3:0] efl, int ecnt, bit eo, bit eu);
    sb_t e;
    @(negedge clk);
    push = ps; pop = pp; pc = ipc; fl = ifl; clr = iclr;
    e.nm = nm; e.sel = sel; e.exp = mk(epc, efl, ecnt, eo, eu);
    sb.push_back(e);
  endtask

  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.nm, e.sel ? act1 : act0, e.exp);
      end
    end
  end

  initial begin
    #2;
    check("reset_async", act0, mk(9'h0, 4'h0, 0, 0, 0));
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    step("idle_after_reset", 0, 0, 0, 9'h0,   4'h0, 0, 9'h000, 4'h0, 0, 0, 0);
    step("push_1e1",         0, 1, 0, 9'h1E1, 4'h9, 0, 9'h1E1, 4'h9, 1, 0, 0);
    step("pop_to_empty",     0, 0, 1, 9'h0,   4'h0, 0, 9'h000, 4'h0, 0, 0, 0);

    step("push_010", 0, 1, 0, 9'h010, 4'h1, 0, 9'h010, 4'h1, 1, 0, 0);
    step("push_020", 0, 1, 0, 9'h020, 4'h2, 0, 9'h020, 4'h2, 2, 0, 0);
    step("push_030", 0, 1, 0, 9'h030, 4'h3, 0, 9'h030, 4'h3, 3, 0, 0);
    step("pop_020",  0, 0, 1, 9'h0,   4'h0, 0, 9'h020, 4'h2, 2, 0, 0);
    step("pop_010",  0, 0, 1, 9'h0,   4'h0, 0, 9'h010, 4'h1, 1, 0, 0);
    step("pop_last", 0, 0, 1, 9'h0,   4'h0, 0, 9'h000, 4'h0, 0, 0, 0);

    step("pop_empty_udf",   0, 0, 1, 9'h0, 4'h0, 0, 9'h000, 4'h0, 0, 0, 1);
    step("clear_udf",       0, 0, 0, 9'h0, 4'h0, 1, 9'h000, 4'h0, 0, 0, 0);
    step("clear_vs_udf",    0, 0, 1, 9'h0, 4'h0, 1, 9'h000, 4'h0, 0, 0, 1);
    step("clear_udf_again", 0, 0, 0, 9'h0, 4'h0, 1, 9'h000, 4'h0, 0, 0, 0);

    step("push_001",       0, 1, 0, 9'h001, 4'h1, 0, 9'h001, 4'h1, 1, 0, 0);
    step("push_002",       0, 1, 0, 9'h002, 4'h2, 0, 9'h002, 4'h2, 2, 0, 0);
    step("replace_0aa",    0, 1, 1, 9'h0AA, 4'h3, 0, 9'h0AA, 4'h3, 2, 0, 0);
    step("pop_after_repl", 0, 0, 1, 9'h0,   4'h0, 0, 9'h001, 4'h1, 1, 0, 0);
    step("pop_repl_empty", 0, 0, 1, 9'h0,   4'h0, 0, 9'h000, 4'h0, 0, 0, 0);

    step("pushpop_on_empty", 0, 1, 1, 9'h077, 4'h7, 0, 9'h077, 4'h7, 1, 0, 0);
    step("pop_077",          0, 0, 1, 9'h0,   4'h0, 0, 9'h000, 4'h0, 0, 0, 0);

    for (int i = 1; i <= 8; i++)
      step($sformatf("drop_push_%0d", i), 0, 1, 0, 9'(i), 4'(i), 0, 9'(i), 4'(i), i, 0, 0);
    step("drop_push_9_full", 0, 1, 0, 9'h009, 4'h9, 0, 9'h008, 4'h8, 8, 1, 0);
    for (int k = 1; k <= 7; k++)
      step($sformatf("drop_pop_%0d", k), 0, 0, 1, 9'h0, 4'h0, 0, 9'(8 - k), 4'(8 - k), 8 - k, 1, 0);
    step("drop_pop_8", 0, 0, 1, 9'h0, 4'h0, 0, 9'h000, 4'h0, 0, 1, 0);
    step("drop_clear_ovf", 0, 0, 0, 9'h0, 4'h0, 1, 9'h000, 4'h0, 0, 0, 0);

    for (int i = 1; i <= 8; i++)
      step($sformatf("wrap_push_%0d", i), 1, 1, 0, 9'(i), 4'(i), 0, 9'(i), 4'(i), i, 0, 0);
    step("wrap_push_9_over", 1, 1, 0, 9'h009, 4'h9, 0, 9'h009, 4'h9, 8, 1, 0);
    for (int k = 1; k <= 7; k++)
      step($sformatf("wrap_pop_%0d", k), 1, 0, 1, 9'h0, 4'h0, 0, 9'(9 - k), 4'(9 - k), 8 - k, 1, 0);
    step("wrap_pop_8", 1, 0, 1, 9'h0, 4'h0, 0, 9'h000, 4'h0, 0, 1, 0);
    step("wrap_clear_ovf", 1, 0, 0, 9'h0, 4'h0, 1, 9'h000, 4'h0, 0, 0, 0);
    step("drop_idle_clean", 0, 0, 0, 9'h0, 4'h0, 1, 9'h000, 4'h0, 0, 0, 0);

    step("rst_push_a", 0, 1, 0, 9'h0A1, 4'h1, 0, 9'h0A1, 4'h1, 1, 0, 0);
    step("rst_push_b", 0, 1, 0, 9'h0A2, 4'h2, 0, 9'h0A2, 4'h2, 2, 0, 0);
    step("rst_push_c", 0, 1, 0, 9'h0A3, 4'h3, 0, 9'h0A3, 4'h3, 3, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midcycle_reset", act0, mk(9'h0, 4'h0, 0, 0, 0));
    rst_n = 1'b1;
    step("push_055_after_rst", 0, 1, 0, 9'h055, 4'h5, 0, 9'h055, 4'h5, 1, 0, 0);
    step("final_idle",         0, 0, 0, 9'h0,   4'h0, 0, 9'h055, 4'h5, 1, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #4;
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
